arduino_irq_scheduler: RTL and testbench

//  Arbitrates NUM_EVENTS vision-pipeline event sources onto the single Arduino interrupt line.

---
 rtl/arduino_irq_scheduler.sv | 198 +++++++++++++++++++
 tb/tb_arduino_irq_scheduler.sv | 338 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/arduino_irq_scheduler.sv
// arduino_irq_scheduler
// Multiplexes NUM_EVENTS vision-pipeline event requests onto the single
// Arduino interrupt line. Each interrupt is a pulse that ends on ack or
// timeout, followed by a minimum low gap. Requests are latched as sticky
// pending bits and granted round-robin. An Avalon-MM slave exposes
// pending, mask, status and an issued-interrupt counter.
//
// state   | meaning
// IDLE    | waiting for an eligible (pending & mask) event
// ASSERT  | irq_out high, waiting for ack or pulse timeout
// HOLDOFF | irq_out low, enforcing the minimum gap between pulses
module arduino_irq_scheduler #(
  parameter int NUM_EVENTS   = 4,
  parameter int PULSE_CYCLES = 50,
  parameter int GAP_CYCLES   = 1000,
  parameter int CNT_W        = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [1:0]            address,
  input  logic                  chipselect,
  input  logic                  write_n,
  input  logic [31:0]           writedata,
  output logic [31:0]           readdata,
  input  logic [NUM_EVENTS-1:0] event_req,
  input  logic                  irq_ack,
  output logic                  irq_out,
  output logic [2:0]            irq_id
);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ASSERT  = 2'd1,
    ST_HOLDOFF = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] PULSE_LAST = CNT_W'(PULSE_CYCLES - 1);
  localparam logic [CNT_W-1:0] GAP_LAST   = CNT_W'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);
  localparam logic [2:0]       LAST_INIT  = 3'(NUM_EVENTS - 1);
  localparam logic [3:0]       NUM_EV4    = 4'(NUM_EVENTS);

  state_t                 state_q;
  logic [CNT_W-1:0]       counter_q;
  logic [NUM_EVENTS-1:0]  pending_q;
  logic [NUM_EVENTS-1:0]  pending_d;
  logic [NUM_EVENTS-1:0]  mask_q;
  logic [2:0]             last_grant_q;
  logic [2:0]             irq_id_q;
  logic                   irq_out_q;
  logic                   timeout_flag_q;
  logic [15:0]            issue_count_q;

  logic                   bus_wr;
  logic                   wr_mask;
  logic                   wr_w1c;
  logic                   wr_cnt_clr;
  logic [NUM_EVENTS-1:0]  eligible;
  logic [7:0]             eligible_ext;
  logic                   grant_valid;
  logic [2:0]             grant_idx;
  logic [3:0]             scan_sum;
  logic [2:0]             scan_idx;
  logic                   issue_now;
  logic [NUM_EVENTS-1:0]  grant_clr;
  logic [NUM_EVENTS-1:0]  w1c_clr;
  logic                   unused_writedata;

  assign bus_wr     = chipselect & ~write_n;
  assign wr_mask    = bus_wr && (address == 2'd1);
  assign wr_w1c     = bus_wr && (address == 2'd2);
  assign wr_cnt_clr = bus_wr && (address == 2'd3);

  assign unused_writedata = ^writedata;

  assign eligible     = pending_q & mask_q;
  assign eligible_ext = 8'(eligible);

  // Round-robin search starting one index past the last grant, wrapping
  always_comb begin
    grant_valid = 1'b0;
    grant_idx   = last_grant_q;
    scan_sum    = '0;
    scan_idx    = '0;
    for (int k = 1; k <= NUM_EVENTS; k++) begin
      scan_sum = {1'b0, last_grant_q} + 4'(k);
      if (scan_sum >= NUM_EV4) begin
        scan_sum = scan_sum - NUM_EV4;
      end
      scan_idx = scan_sum[2:0];
      if (!grant_valid && eligible_ext[scan_idx]) begin
        grant_valid = 1'b1;
        grant_idx   = scan_idx;
      end
    end
  end

  assign issue_now = (state_q == ST_IDLE) && grant_valid;

  // Pending is sticky; a new request on the same edge wins over any clear
  always_comb begin
    grant_clr = '0;
    if (issue_now) begin
      grant_clr = NUM_EVENTS'(1) << grant_idx;
    end
    w1c_clr = '0;
    if (wr_w1c) begin
      w1c_clr = writedata[NUM_EVENTS-1:0];
    end
    pending_d = (pending_q & ~grant_clr & ~w1c_clr) | event_req;
  end

  // Sequencer FSM, bus-visible registers and registered outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q        <= ST_IDLE;
      counter_q      <= '0;
      pending_q      <= '0;
      mask_q         <= '1;
      last_grant_q   <= LAST_INIT;
      irq_id_q       <= '0;
      irq_out_q      <= 1'b0;
      timeout_flag_q <= 1'b0;
      issue_count_q  <= '0;
    end else begin
      pending_q <= pending_d;

      if (wr_mask) begin
        mask_q <= writedata[NUM_EVENTS-1:0];
      end

      if (wr_cnt_clr) begin
        issue_count_q <= '0;
      end else if (issue_now && (issue_count_q != 16'hFFFF)) begin
        issue_count_q <= issue_count_q + 16'd1;
      end

      case (state_q)
        ST_IDLE: begin
          if (grant_valid) begin
            irq_id_q     <= grant_idx;
            last_grant_q <= grant_idx;
            irq_out_q    <= 1'b1;
            counter_q    <= '0;
            state_q      <= ST_ASSERT;
          end
        end

        ST_ASSERT: begin
          if (irq_ack) begin
            irq_out_q      <= 1'b0;
            timeout_flag_q <= 1'b0;
            counter_q      <= '0;
            state_q        <= (GAP_CYCLES == 0) ? ST_IDLE : ST_HOLDOFF;
          end else if (counter_q == PULSE_LAST) begin
            irq_out_q      <= 1'b0;
            timeout_flag_q <= 1'b1;
            counter_q      <= '0;
            state_q        <= (GAP_CYCLES == 0) ? ST_IDLE : ST_HOLDOFF;
          end else begin
            counter_q <= counter_q + 1'b1;
          end
        end

        ST_HOLDOFF: begin
          if (counter_q == GAP_LAST) begin
            counter_q <= '0;
            state_q   <= ST_IDLE;
          end else begin
            counter_q <= counter_q + 1'b1;
          end
        end

        default: begin
          irq_out_q <= 1'b0;
          counter_q <= '0;
          state_q   <= ST_IDLE;
        end
      endcase
    end
  end

  assign irq_out = irq_out_q;
  assign irq_id  = irq_id_q;

  // Zero-wait read mux; bits above NUM_EVENTS read as zero
  always_comb begin
    readdata = '0;
    if (chipselect) begin
      case (address)
        2'd0:    readdata = 32'(pending_q);
        2'd1:    readdata = 32'(mask_q);
        2'd2:    readdata = {22'b0, state_q, 3'b0, timeout_flag_q, 1'b0, irq_id_q};
        default: readdata = {16'b0, issue_count_q};
      endcase
    end
  end

endmodule

// File: tb/tb_arduino_irq_scheduler.sv
// tb_arduino_irq_scheduler
// Directed scenarios plus a randomized phase, checked against a
// timeline-based reference model (pulse start/end timestamps, sticky
// pending set, round-robin pointer).
module tb_arduino_irq_scheduler;

  localparam int N     = 4;
  localparam int PULSE = 50;
  localparam int GAP   = 1000;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic [1:0]   address = '0;
  logic         chipselect = 1'b0;
  logic         write_n = 1'b1;
  logic [31:0]  writedata = '0;
  logic [31:0]  readdata;
  logic [N-1:0] event_req = '0;
  logic         irq_ack = 1'b0;
  logic         irq_out;
  logic [2:0]   irq_id;

  arduino_irq_scheduler #(
    .NUM_EVENTS  (N),
    .PULSE_CYCLES(PULSE),
    .GAP_CYCLES  (GAP),
    .CNT_W       (16)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .address   (address),
    .chipselect(chipselect),
    .write_n   (write_n),
    .writedata (writedata),
    .readdata  (readdata),
    .event_req (event_req),
    .irq_ack   (irq_ack),
    .irq_out   (irq_out),
    .irq_id    (irq_id)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  bit chk_en = 1'b0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  // Reference model: edge counter plus pulse timestamps
  int       cyc = 0;
  logic [N-1:0] m_pend = '0;
  logic [N-1:0] m_mask = '1;
  int       m_last = N - 1;
  int       m_id = 0;
  bit       m_to = 1'b0;
  bit       m_on = 1'b0;
  int       m_tg = 0;
  int       m_tarb = 0;
  int       m_cnt = 0;

  task automatic model_step();
    logic [N-1:0] clr;
    bit wr;
    bit granted;
    int start;
    cyc++;
    if (reset) begin
      m_pend = '0; m_mask = '1; m_last = N - 1; m_id = 0; m_to = 1'b0;
      m_on = 1'b0; m_tarb = 0; m_cnt = 0;
      return;
    end
    clr = '0;
    granted = 1'b0;
    wr = chipselect && !write_n;
    start = m_last;
    if (m_on) begin
      if (irq_ack || (cyc - m_tg) == PULSE) begin
        m_on = 1'b0;
        m_to = !irq_ack;
        m_tarb = cyc + GAP + 1;
      end
    end else if (cyc >= m_tarb) begin
      for (int k = 1; k <= N; k++) begin
        int idx = (start + k) % N;
        if (!granted && m_pend[idx] && m_mask[idx]) begin
          granted = 1'b1;
          clr[idx] = 1'b1;
          m_id = idx;
          m_last = idx;
          m_on = 1'b1;
          m_tg = cyc;
        end
      end
    end
    if (wr && address == 2'd1) m_mask = writedata[N-1:0];
    if (wr && address == 2'd2) clr = clr | writedata[N-1:0];
    if (wr && address == 2'd3) m_cnt = 0;
    else if (granted && m_cnt < 65535) m_cnt++;
    m_pend = (m_pend & ~clr) | event_req;
  endtask

  function automatic logic [31:0] model_rd(input logic [1:0] a);
    logic [1:0] st;
    st = m_on ? 2'd1 : ((cyc < m_tarb - 1) ? 2'd2 : 2'd0);
    case (a)
      2'd0:    return 32'(m_pend);
      2'd1:    return 32'(m_mask);
      2'd2:    return {22'b0, st, 3'b0, m_to, 1'b0, 3'(m_id)};
      default: return 32'(m_cnt);
    endcase
  endfunction

  initial forever begin
    @(posedge clk);
    model_step();
  end

  initial forever begin
    @(negedge clk);
    if (chk_en) begin
      check_eq("irq_out", 32'(irq_out), 32'(m_on));
      check_eq("irq_id", 32'(irq_id), 32'(m_id));
    end
  end

  task automatic bus_read(input logic [1:0] a, output logic [31:0] d);
    @(negedge clk);
    address = a; chipselect = 1'b1; write_n = 1'b1;
    #1;
    d = readdata;
    check_eq($sformatf("rd%0d", a), readdata, model_rd(a));
    chipselect = 1'b0;
  endtask

  task automatic bus_write(input logic [1:0] a, input logic [31:0] d);
    @(negedge clk);
    address = a; writedata = d; chipselect = 1'b1; write_n = 1'b0;
    @(negedge clk);
    chipselect = 1'b0; write_n = 1'b1;
  endtask

  task automatic pulse_req(input logic [N-1:0] r);
    @(negedge clk);
    event_req = r;
    @(negedge clk);
    event_req = '0;
  endtask

  task automatic wait_rise(input int budget, output int rc);
    rc = -1;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (irq_out === 1'b1) begin
        rc = cyc;
        return;
      end
    end
    check_eq("wait_rise", 32'(irq_out), 32'd1);
  endtask

  task automatic wait_fall(input int budget, output int fc);
    fc = -1;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (irq_out === 1'b0) begin
        fc = cyc;
        return;
      end
    end
    check_eq("wait_fall", 32'(irq_out), 32'd0);
  endtask

  task automatic quick_ack();
    @(negedge clk);
    irq_ack = 1'b1;
    @(negedge clk);
    irq_ack = 1'b0;
  endtask

  logic [31:0] d;
  int r, f, r2, f2;

  initial begin
    // T1: reset values, single timed-out pulse, gap, status
    reset = 1'b1;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    chk_en = 1'b1;
    bus_read(2'd0, d); check_eq("T1 rst pend", d, 32'h0);
    bus_read(2'd1, d); check_eq("T1 rst mask", d, 32'hF);
    bus_read(2'd3, d); check_eq("T1 rst cnt", d, 32'h0);
    @(negedge clk);
    event_req = 4'b0100;
    @(negedge clk);
    event_req = '0;
    check_eq("T1 lat edge1", 32'(irq_out), 32'd0);
    @(negedge clk);
    check_eq("T1 lat edge2", 32'(irq_out), 32'd1);
    check_eq("T1 id", 32'(irq_id), 32'd2);
    r = cyc;
    wait_fall(200, f);
    check_eq("T1 width", 32'(f - r), 32'd50);
    bus_read(2'd2, d); check_eq("T1 timeout", 32'(d[4]), 32'd1);
    check_eq("T1 state holdoff", 32'(d[9:8]), 32'd2);
    bus_read(2'd3, d); check_eq("T1 cnt", d, 32'd1);
    #1 check_eq("T1 rd no cs", readdata, 32'h0);
    pulse_req(4'b1000);
    wait_rise(2100, r2);
    check_eq("T1 gap>=1000", 32'((r2 - f) >= GAP), 32'd1);
    check_eq("T1 id2", 32'(irq_id), 32'd3);
    wait_fall(200, f2);

    // T2: ack on 5th high cycle; ack outside ASSERT ignored
    pulse_req(4'b0010);
    wait_rise(2100, r);
    repeat (4) @(negedge clk);
    irq_ack = 1'b1;
    @(negedge clk);
    irq_ack = 1'b0;
    check_eq("T2 ack drop", 32'(irq_out), 32'd0);
    check_eq("T2 width", 32'(cyc - r), 32'd5);
    bus_read(2'd2, d); check_eq("T2 timeout", 32'(d[4]), 32'd0);
    check_eq("T2 id", 32'(d[2:0]), 32'd1);
    @(negedge clk); irq_ack = 1'b1;
    repeat (10) @(negedge clk);
    irq_ack = 1'b0;

    // T3: round-robin order after reset, then pending {0,2} after grant 1
    @(negedge clk); reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    pulse_req(4'b1111);
    for (int j = 0; j < 4; j++) begin
      wait_rise(2100, r);
      check_eq($sformatf("T3 order%0d", j), 32'(irq_id), 32'(j));
      quick_ack();
    end
    pulse_req(4'b0010);
    wait_rise(2100, r);
    check_eq("T3 id1", 32'(irq_id), 32'd1);
    pulse_req(4'b0101);
    quick_ack();
    wait_rise(2100, r);
    check_eq("T3 rr 2 first", 32'(irq_id), 32'd2);
    quick_ack();
    wait_rise(2100, r);
    check_eq("T3 rr then 0", 32'(irq_id), 32'd0);
    quick_ack();

    // T4: masked event latches pending but is not signalled
    bus_write(2'd1, 32'hE);
    wait_fall(10, f);
    repeat (1100) @(negedge clk);
    pulse_req(4'b0001);
    repeat (20) @(negedge clk);
    check_eq("T4 masked", 32'(irq_out), 32'd0);
    bus_read(2'd0, d); check_eq("T4 pend", d, 32'h1);
    bus_write(2'd1, 32'hF);
    wait_rise(50, r);
    check_eq("T4 id", 32'(irq_id), 32'd0);
    quick_ack();

    // T5: set beats same-edge W1C; W1C alone clears; addr0 writes ignored
    bus_write(2'd1, 32'h0);
    @(negedge clk);
    event_req = 4'b0100;
    address = 2'd2; writedata = 32'h4; chipselect = 1'b1; write_n = 1'b0;
    @(negedge clk);
    event_req = '0; chipselect = 1'b0; write_n = 1'b1;
    bus_read(2'd0, d); check_eq("T5 set wins", 32'(d[2]), 32'd1);
    bus_write(2'd0, 32'h0);
    bus_read(2'd0, d); check_eq("T5 ro pend", d, 32'h4);
    bus_write(2'd2, 32'h4);
    bus_read(2'd0, d); check_eq("T5 w1c", d, 32'h0);
    bus_write(2'd1, 32'hF);

    // T6: reset mid-pulse
    pulse_req(4'b1000);
    wait_rise(2100, r);
    bus_write(2'd1, 32'h5);
    pulse_req(4'b0011);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check_eq("T6 rst irq", 32'(irq_out), 32'd0);
    reset = 1'b0;
    bus_read(2'd0, d); check_eq("T6 pend", d, 32'h0);
    bus_read(2'd1, d); check_eq("T6 mask", d, 32'hF);
    bus_read(2'd3, d); check_eq("T6 cnt", d, 32'h0);

    // Randomized traffic against the model
    for (int i = 0; i < 15000; i++) begin
      @(negedge clk);
      event_req  = ($urandom_range(0, 19) == 0) ? N'($urandom) : '0;
      irq_ack    = ($urandom_range(0, 15) == 0);
      chipselect = 1'b0;
      write_n    = 1'b1;
      case ($urandom_range(0, 9))
        0: begin
          address = 2'($urandom);
          chipselect = 1'b1;
          #1 check_eq("rnd rd", readdata, model_rd(address));
        end
        1: begin
          if ($urandom_range(0, 7) == 0) begin
            address = 2'($urandom);
            writedata = (address == 2'd1 && $urandom_range(0, 3) != 0) ? 32'hF : $urandom;
            chipselect = 1'b1;
            write_n = 1'b0;
          end
        end
        default: ;
      endcase
    end
    @(negedge clk);
    chipselect = 1'b0; write_n = 1'b1; event_req = '0; irq_ack = 1'b0;
    bus_read(2'd2, d);
    bus_read(2'd3, d);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog expired at cyc=%0d", cyc);
    $display("test done: total=%0d bad=%0d", total, bad + 1);
    $fatal(1, "watchdog");
  end

endmodule
